// File: rtl/param_multicycle_core.sv
// Multi-cycle execute core: one instruction per valid/ready handshake, then an
// execute phase and a write-back phase into a parameterised register file.
module param_multicycle_core #(
    parameter int DATA_W  = 16,
    parameter int NREGS   = 8,
    parameter int INSTR_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [INSTR_W-1:0]       instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    output logic [DATA_W-1:0]        d_out,
    output logic                     done,
    output logic                     illegal,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);
    localparam int RAW   = $clog2(NREGS);
    localparam int RAW2  = $clog2(DATA_W);
    localparam int IMM_W = INSTR_W - RAW - 5;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    state_t state;
    state_t state_next;

    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  result_q;
    logic [DATA_W-1:0]  regs [NREGS];

    logic [RAW-1:0]    rx;
    logic [RAW-1:0]    ry;
    logic [IMM_W-1:0]  imm_raw;
    logic [DATA_W-1:0] imm;
    logic [2:0]        op;
    logic [1:0]        fmt;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] alu_res;
    logic              accept;
    logic              exec_en;
    logic              wb_en;
    logic              wb_write;

    // The immediate overlaps the ry field; decoding always works from the latched word.
    assign rx      = instr_q[INSTR_W-1 -: RAW];
    assign ry      = instr_q[INSTR_W-1-RAW -: RAW];
    assign imm_raw = instr_q[INSTR_W-1-RAW:5];
    assign op      = instr_q[4:2];
    assign fmt     = instr_q[1:0];

    generate
        if (IMM_W >= DATA_W) begin : g_imm_trunc
            assign imm = imm_raw[DATA_W-1:0];
        end else begin : g_imm_ext
            assign imm = {{(DATA_W-IMM_W){1'b0}}, imm_raw};
        end
    endgenerate

    assign a = regs[rx];
    assign b = (fmt == 2'd1) ? imm : regs[ry];

    always_comb begin
        alu_res = '0;
        if (fmt == 2'd2) begin
            alu_res = b;
        end else begin
            case (op)
                3'd0: alu_res = a + b;
                3'd1: alu_res = a - b;
                3'd2: alu_res = a & b;
                3'd3: alu_res = a | b;
                3'd4: alu_res = a ^ b;
                3'd5: alu_res = a << b[RAW2-1:0];
                3'd6: alu_res = a >> b[RAW2-1:0];
                3'd7: alu_res = {{(DATA_W-1){1'b0}}, (a < b)};
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        exec_en     = 1'b0;
        wb_en       = 1'b0;
        if (run) begin
            unique case (state)
                IDLE: begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        accept     = 1'b1;
                        state_next = EXEC;
                    end
                end
                EXEC: begin
                    exec_en    = 1'b1;
                    state_next = WB;
                end
                WB: begin
                    wb_en      = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign wb_write = wb_en && (fmt != 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // done/illegal clear on every edge, so a pulse ends even while run is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q  <= '0;
            result_q <= '0;
            d_out    <= '0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            done    <= wb_en;
            illegal <= wb_en && (fmt == 2'd3);
            if (accept) begin
                instr_q <= instr;
            end
            if (exec_en) begin
                result_q <= alu_res;
            end
            if (wb_write) begin
                d_out <= result_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[rx] <= result_q;
        end
    end

    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_param_multicycle_core.sv
// Bench: two core instances (16b/8 regs and 32b/16 regs/24b instr) driven in lockstep
// and compared every cycle against an instruction-level model of the core.
module tb_param_multicycle_core;
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SHL  = 5;
    localparam int OP_SLTU = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        instr_valid;
    logic [15:0] instr0;
    logic [23:0] instr1;
    logic        ready0, ready1;
    logic        done0, done1;
    logic        ill0, ill1;
    logic [15:0] dout0, dbg0;
    logic [31:0] dout1, dbg1;
    logic [2:0]  dbg_addr0;
    logic [3:0]  dbg_addr1;

    int checks = 0;
    int errors = 0;

    longint unsigned m_regs [2][16];
    longint unsigned m_dout [2];
    longint unsigned pend_val [2];
    int              pend_rx [2];
    bit              pend_ill [2];
    bit              exp_ill [2];
    bit              busy = 1'b0;
    bit              exp_done = 1'b0;
    int              rem = 0;

    always #5 clk = ~clk;

    param_multicycle_core u_dut0 (
        .clk(clk), .reset(reset), .run(run), .instr(instr0), .instr_valid(instr_valid),
        .instr_ready(ready0), .d_out(dout0), .done(done0), .illegal(ill0),
        .dbg_addr(dbg_addr0), .dbg_data(dbg0)
    );

    param_multicycle_core #(.DATA_W(32), .NREGS(16), .INSTR_W(24)) u_dut1 (
        .clk(clk), .reset(reset), .run(run), .instr(instr1), .instr_valid(instr_valid),
        .instr_ready(ready1), .d_out(dout1), .done(done1), .illegal(ill1),
        .dbg_addr(dbg_addr1), .dbg_data(dbg1)
    );

    function automatic int dw_of(input int k);
        return (k == 0) ? 16 : 32;
    endfunction

    function automatic int raw_of(input int k);
        return (k == 0) ? 3 : 4;
    endfunction

    function automatic int iw_of(input int k);
        return (k == 0) ? 16 : 24;
    endfunction

    function automatic longint unsigned mask_of(input int n);
        return (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [23:0] enc_ri(input int k, input int rx, input int imm, input int op);
        longint unsigned v;
        v = (64'(rx) << (iw_of(k) - raw_of(k))) |
            ((64'(imm) & mask_of(iw_of(k) - raw_of(k) - 5)) << 5) |
            (64'(op) << 2) | 64'd1;
        return v[23:0];
    endfunction

    function automatic logic [23:0] enc_rr(input int k, input int rx, input int ry, input int op, input int fmt);
        longint unsigned v;
        v = (64'(rx) << (iw_of(k) - raw_of(k))) |
            (64'(ry) << (iw_of(k) - 2 * raw_of(k))) |
            (64'(op) << 2) | 64'(fmt);
        return v[23:0];
    endfunction

    function automatic longint unsigned alu_model(input int k, input int op,
                                                  input longint unsigned a, input longint unsigned b);
        longint unsigned m;
        int sh;
        m  = mask_of(dw_of(k));
        sh = int'(b % 64'(dw_of(k)));
        case (op)
            0: return (a + b) & m;
            1: return (a - b) & m;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (a << sh) & m;
            6: return a >> sh;
            default: return (a < b) ? 64'd1 : 64'd0;
        endcase
    endfunction

    // Whole instruction evaluated at acceptance: execution is serial, so nothing
    // can change the register file before this instruction's own write-back.
    task automatic modelAccept(input int k, input longint unsigned ins);
        int iw, raw, rx, ry, op, fmt;
        longint unsigned imm, a, b;
        iw  = iw_of(k);
        raw = raw_of(k);
        rx  = int'((ins >> (iw - raw)) & mask_of(raw));
        ry  = int'((ins >> (iw - 2 * raw)) & mask_of(raw));
        imm = (ins >> 5) & mask_of(iw - raw - 5) & mask_of(dw_of(k));
        op  = int'((ins >> 2) & 64'd7);
        fmt = int'(ins & 64'd3);
        a   = m_regs[k][rx];
        b   = (fmt == 1) ? imm : m_regs[k][ry];
        pend_val[k] = (fmt == 2) ? b : alu_model(k, op, a, b);
        pend_rx[k]  = rx;
        pend_ill[k] = (fmt == 3);
    endtask

    task automatic checkOutput(input string name, input longint unsigned actual, input longint unsigned expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            checkOutput("rst_done0", 64'(done0), 64'd0);
            checkOutput("rst_done1", 64'(done1), 64'd0);
            checkOutput("rst_illegal0", 64'(ill0), 64'd0);
            checkOutput("rst_illegal1", 64'(ill1), 64'd0);
            checkOutput("rst_dout0", 64'(dout0), 64'd0);
            checkOutput("rst_dout1", 64'(dout1), 64'd0);
            checkOutput("rst_dbg0", 64'(dbg0), 64'd0);
            checkOutput("rst_dbg1", 64'(dbg1), 64'd0);
            busy     = 1'b0;
            rem      = 0;
            exp_done = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_dout[k]  = 0;
                exp_ill[k] = 1'b0;
                for (int r = 0; r < 16; r++) m_regs[k][r] = 0;
            end
        end else begin
            checkOutput("ready0", 64'(ready0), 64'(run && !busy));
            checkOutput("ready1", 64'(ready1), 64'(run && !busy));
            checkOutput("done0", 64'(done0), 64'(exp_done));
            checkOutput("done1", 64'(done1), 64'(exp_done));
            checkOutput("illegal0", 64'(ill0), 64'(exp_ill[0]));
            checkOutput("illegal1", 64'(ill1), 64'(exp_ill[1]));
            checkOutput("dout0", 64'(dout0), m_dout[0]);
            checkOutput("dout1", 64'(dout1), m_dout[1]);
            checkOutput("dbg0", 64'(dbg0), m_regs[0][dbg_addr0]);
            checkOutput("dbg1", 64'(dbg1), m_regs[1][dbg_addr1]);
            // Inputs are stable until the next rising edge: apply its effect now.
            exp_done   = 1'b0;
            exp_ill[0] = 1'b0;
            exp_ill[1] = 1'b0;
            if (run) begin
                if (busy) begin
                    rem--;
                    if (rem == 0) begin
                        busy     = 1'b0;
                        exp_done = 1'b1;
                        for (int k = 0; k < 2; k++) begin
                            exp_ill[k] = pend_ill[k];
                            if (!pend_ill[k]) begin
                                m_regs[k][pend_rx[k]] = pend_val[k];
                                m_dout[k] = pend_val[k];
                            end
                        end
                    end
                end else if (instr_valid) begin
                    busy = 1'b1;
                    rem  = 2;
                    modelAccept(0, 64'(instr0));
                    modelAccept(1, 64'(instr1));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] i0, input logic [23:0] i1, input bit rand_run,
                                 input bit keep_valid, output time hs_t);
        bit hs;
        int n;
        instr0      = i0;
        instr1      = i1;
        instr_valid = 1'b1;
        hs   = 1'b0;
        n    = 0;
        hs_t = 0;
        while (!hs && n < 60) begin
            @(negedge clk);
            hs   = ready0;
            hs_t = $time;
            n++;
            @(posedge clk);
            #1;
            if (rand_run) begin
                run       = ($urandom_range(0, 3) != 0);
                dbg_addr0 = 3'($urandom);
                dbg_addr1 = 4'($urandom);
            end
        end
        if (!hs) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout: got no ready, expected ready within 60 cycles at %0t", $time);
        end
        if (!keep_valid) instr_valid = 1'b0;
        instr0 = 16'($urandom);
        instr1 = 24'($urandom);
    endtask

    task automatic send_ri(input int rx, input int imm, input int op, input bit keep, output time t);
        applyStimulus(16'(enc_ri(0, rx, imm, op)), enc_ri(1, rx, imm, op), 1'b0, keep, t);
    endtask

    task automatic send_rr(input int rx, input int ry, input int op, input int fmt, input bit keep, output time t);
        applyStimulus(16'(enc_rr(0, rx, ry, op, fmt)), enc_rr(1, rx, ry, op, fmt), 1'b0, keep, t);
    endtask

    task automatic waitDone(output int n);
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = done0;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done, expected done within 40 cycles at %0t", $time);
        end
    endtask

    task automatic syncDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        syncDrive();
        reset = 1'b1;
        syncDrive();
        reset = 1'b0;
    endtask

    task automatic readDbg(input int r, input longint unsigned e0, input longint unsigned e1);
        dbg_addr0 = 3'(r);
        dbg_addr1 = 4'(r);
        #1;
        checkOutput($sformatf("dbg0_r%0d", r), 64'(dbg0), e0);
        checkOutput($sformatf("dbg1_r%0d", r), 64'(dbg1), e1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before %0t", $time);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        time t [4];
        time tx;
        int  n;
        reset = 1'b1; run = 1'b0; instr_valid = 1'b0;
        instr0 = '0; instr1 = '0; dbg_addr0 = '0; dbg_addr1 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run   = 1'b1;

        $display("[TB] immediate add and latency");
        send_ri(1, 5, OP_ADD, 1'b0, tx);
        waitDone(n);
        checkOutput("t1_latency", 64'(n), 64'd3);
        checkOutput("t1_dout0", 64'(dout0), 64'h5);
        checkOutput("t1_dout1", 64'(dout1), 64'h5);
        syncDrive();
        readDbg(1, 64'h5, 64'h5);

        $display("[TB] wrap-around arithmetic");
        doReset();
        send_ri(1, 1, OP_SUB, 1'b0, tx);
        waitDone(n);
        checkOutput("t2_neg0", 64'(dout0), 64'hFFFF);
        checkOutput("t2_neg1", 64'(dout1), 64'hFFFF_FFFF);
        syncDrive();
        send_ri(2, 2, OP_ADD, 1'b0, tx);
        waitDone(n);
        syncDrive();
        send_rr(1, 2, OP_ADD, 0, 1'b0, tx);
        waitDone(n);
        checkOutput("t2_wrap0", 64'(dout0), 64'h1);
        checkOutput("t2_wrap1", 64'(dout1), 64'h1);
        syncDrive();
        send_rr(2, 1, OP_SUB, 0, 1'b0, tx);
        waitDone(n);
        checkOutput("t2_sub0", 64'(dout0), 64'h1);
        syncDrive();
        send_rr(2, 1, OP_SLTU, 0, 1'b0, tx);
        waitDone(n);
        checkOutput("t2_sltu0", 64'(dout0), 64'h0);
        checkOutput("t2_sltu1", 64'(dout1), 64'h0);
        syncDrive();
        readDbg(1, 64'h1, 64'h1);

        $display("[TB] run held low during execute");
        send_ri(4, 9, OP_ADD, 1'b0, tx);
        run = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("t3_frozen_done", 64'(done0), 64'd0);
            checkOutput("t3_frozen_dout", 64'(dout0), 64'd0);
        end
        syncDrive();
        run = 1'b1;
        waitDone(n);
        checkOutput("t3_resume_latency", 64'(n), 64'd3);
        checkOutput("t3_dout0", 64'(dout0), 64'h9);
        syncDrive();

        $display("[TB] reset during write-back");
        send_ri(3, 8'h7F, OP_ADD, 1'b0, tx);
        syncDrive();
        reset = 1'b1;
        syncDrive();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t4_no_done", 64'(done0), 64'd0);
            checkOutput("t4_dout0", 64'(dout0), 64'd0);
        end
        syncDrive();
        readDbg(3, 64'h0, 64'h0);

        $display("[TB] illegal format");
        send_ri(5, 8'h33, OP_ADD, 1'b0, tx);
        waitDone(n);
        syncDrive();
        send_rr(5, 5, OP_ADD, 3, 1'b0, tx);
        waitDone(n);
        checkOutput("t5_illegal0", 64'(ill0), 64'd1);
        checkOutput("t5_illegal1", 64'(ill1), 64'd1);
        checkOutput("t5_held_dout0", 64'(dout0), 64'h33);
        @(negedge clk);
        checkOutput("t5_pulse_end", 64'(ill0), 64'd0);
        syncDrive();
        readDbg(5, 64'h33, 64'h33);

        $display("[TB] back-to-back stream");
        send_ri(1, 3, OP_ADD, 1'b1, t[0]);
        send_ri(2, 4, OP_ADD, 1'b1, t[1]);
        send_rr(1, 2, OP_SHL, 0, 1'b1, t[2]);
        send_rr(6, 1, OP_SLTU, 2, 1'b0, t[3]);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t6_spacing%0d", i), 64'(t[i+1] - t[i]), 64'd30);
        end
        waitDone(n);
        checkOutput("t6_mov0", 64'(dout0), 64'h30);
        checkOutput("t6_mov1", 64'(dout1), 64'h30);
        syncDrive();
        readDbg(6, 64'h30, 64'h30);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(16'($urandom), 24'($urandom), 1'b1, 1'($urandom_range(0, 1)), tx);
            if (i % 97 == 96) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                doReset();
            end
        end
        instr_valid = 1'b0;
        run = 1'b1;
        repeat (8) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
